char_pixel_gen: RTL and testbench

CHAR_PIXEL_GEN -- requirements
Module: char_pixel_gen

---
 rtl/char_pixel_gen.sv | 183 ++++++++++++++++++
 tb/tb_char_pixel_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/char_pixel_gen.sv
// Text-mode pixel generator: maps the raster position onto a character grid, fetches
// glyph rows from an external text buffer and font ROM, and overlays a blinking underline cursor.
module char_pixel_gen #(
    parameter int          CHAR_HEIGHT  = 16,
    parameter int          TEXT_COLS    = 80,
    parameter int          TEXT_ROWS    = 30,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_char,
    output logic [11:0] char_address,
    input  logic [7:0]  data_rom,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam logic [7:0]  COLS_LIM  = 8'(TEXT_COLS);
    localparam logic [5:0]  ROWS_LIM  = 6'(TEXT_ROWS);
    localparam logic [11:0] COLS_MUL  = 12'(TEXT_COLS);
    localparam logic [4:0]  CUR_START = 5'(CHAR_HEIGHT - 2);
    localparam int          FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [6:0]  col_s;
    logic [4:0]  row_s;
    logic        in_text_s;
    logic        hit_s;
    logic        unused_s;

    logic [FW-1:0] frame_cnt_r;
    logic          blink_phase_r;
    logic          vsync_prev_r;

    logic [3:0]  glyph_row_1_r;
    logic [2:0]  xoff_1_r;
    logic        hit_1_r;
    logic        in_text_1_r;
    logic        hsync_1_r;
    logic        vsync_1_r;
    logic        blank_1_r;

    logic [7:0]  rom_2_r;
    logic [2:0]  xoff_2_r;
    logic        hit_2_r;
    logic        in_text_2_r;
    logic        hsync_2_r;
    logic        vsync_2_r;
    logic        blank_2_r;

    logic        pixel_s;
    logic [11:0] rgb_s;

    assign col_s    = hcount[9:3];
    assign row_s    = vcount[8:4];
    assign unused_s = ^{hcount[10], vcount[10:9]};

    // Stage 0: text-grid lookup, buffer address and cursor hit
    always_comb begin
        in_text_s = ({1'b0, col_s} < COLS_LIM) && ({1'b0, row_s} < ROWS_LIM);
        hit_s     = 1'b0;
        text_addr = 12'd0;
        if (in_text_s) begin
            text_addr = ({7'd0, row_s} * COLS_MUL) + {5'd0, col_s};
        end else begin
            text_addr = 12'd0;
        end
        // Out-of-range cursor coordinates never match an on-screen cell, so no clamping is needed
        if (cursor_en && blink_phase_r && (col_s == cursor_col) && (row_s == cursor_row)
            && ({1'b0, vcount[3:0]} >= CUR_START)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Blink timebase: counts vsync rising edges, toggles phase every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
            vsync_prev_r  <= 1'b0;
        end else begin
            vsync_prev_r <= vsync_in;
            if (vsync_in && !vsync_prev_r) begin
                if (frame_cnt_r == FRAME_LAST) begin
                    frame_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + FW'(1);
                end
            end
        end
    end

    // Stage 1 registers: text_char arrives from the buffer alongside these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_row_1_r <= 4'd0;
            xoff_1_r      <= 3'd0;
            hit_1_r       <= 1'b0;
            in_text_1_r   <= 1'b0;
            hsync_1_r     <= 1'b0;
            vsync_1_r     <= 1'b0;
            blank_1_r     <= 1'b1;
        end else begin
            glyph_row_1_r <= vcount[3:0];
            xoff_1_r      <= hcount[2:0];
            hit_1_r       <= hit_s;
            in_text_1_r   <= in_text_s;
            hsync_1_r     <= hsync_in;
            vsync_1_r     <= vsync_in;
            blank_1_r     <= blank_in;
        end
    end

    assign char_address = {text_char, glyph_row_1_r};

    // Stage 2 registers: capture the font row returned for this character
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_2_r     <= 8'd0;
            xoff_2_r    <= 3'd0;
            hit_2_r     <= 1'b0;
            in_text_2_r <= 1'b0;
            hsync_2_r   <= 1'b0;
            vsync_2_r   <= 1'b0;
            blank_2_r   <= 1'b1;
        end else begin
            rom_2_r     <= data_rom;
            xoff_2_r    <= xoff_1_r;
            hit_2_r     <= hit_1_r;
            in_text_2_r <= in_text_1_r;
            hsync_2_r   <= hsync_1_r;
            vsync_2_r   <= vsync_1_r;
            blank_2_r   <= blank_1_r;
        end
    end

    // Colour selection: blank dominates, then off-grid background, then glyph XOR cursor
    always_comb begin
        pixel_s = rom_2_r[3'd7 - xoff_2_r];
        rgb_s   = BG_COLOR;
        if (blank_2_r) begin
            rgb_s = 12'h000;
        end else if (!in_text_2_r) begin
            rgb_s = BG_COLOR;
        end else if (pixel_s ^ hit_2_r) begin
            rgb_s = FG_COLOR;
        end else begin
            rgb_s = BG_COLOR;
        end
    end

    // Output registers: colour and timing leave with identical 3-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            rgb       <= rgb_s;
            hsync_out <= hsync_2_r;
            vsync_out <= vsync_2_r;
            blank_out <= blank_2_r;
        end
    end

endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed bench for char_pixel_gen with a registered text-buffer model and a small font ROM model.
module tb_char_pixel_gen;

    localparam logic [11:0] FG = 12'hFF0;
    localparam logic [11:0] BG = 12'h00F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, vcount;
    logic        hsync_in, vsync_in, blank_in;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic [11:0] text_addr;
    logic [7:0]  text_char;
    logic [11:0] char_address;
    logic [7:0]  data_rom;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, blank_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [11:0] exp_rgb;
        logic        exp_hs;
        logic        exp_vs;
        logic        exp_blank;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    char_pixel_gen #(
        .CHAR_HEIGHT(16), .TEXT_COLS(80), .TEXT_ROWS(30),
        .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .text_addr(text_addr), .text_char(text_char), .char_address(char_address),
        .data_rom(data_rom), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    // Text buffer: one-cycle read latency; cell 1 holds 'B', everything else 'A'
    always @(posedge clk) text_char <= (text_addr == 12'd1) ? 8'h42 : 8'h41;

    // Font ROM: combinational
    always_comb begin
        case (char_address)
            12'h415: data_rom = 8'h18;
            12'h413: data_rom = 8'hF0;
            12'h425: data_rom = 8'h81;
            default: data_rom = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [10:0] hc, input logic [10:0] vc, input logic [11:0] exp,
                       input string name);
        @(negedge clk);
        hcount = hc; vcount = vc; blank_in = 1'b0;
        repeat (3) @(negedge clk);
        chk(name, rgb, exp);
    endtask

    task automatic vs_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); vsync_in = 1'b1;
            @(negedge clk); vsync_in = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        hcount = 11'd0; vcount = 11'd0;
        hsync_in = 1'b1; vsync_in = 1'b0; blank_in = 1'b0;
        cursor_col = 7'd0; cursor_row = 5'd0; cursor_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{11'(i), 11'd5, 1'b0, 1'b0, 1'b0,
                        ((i == 3) || (i == 4)) ? FG : BG, 1'b0, 1'b0, 1'b0};
        end
        vecs[8]  = '{11'd8,   11'd5,   1'b0, 1'b0, 1'b0, FG,      1'b0, 1'b0, 1'b0};
        vecs[9]  = '{11'd12,  11'd5,   1'b0, 1'b0, 1'b0, BG,      1'b0, 1'b0, 1'b0};
        vecs[10] = '{11'd15,  11'd5,   1'b0, 1'b0, 1'b0, FG,      1'b0, 1'b0, 1'b0};
        vecs[11] = '{11'd17,  11'd35,  1'b0, 1'b0, 1'b0, FG,      1'b0, 1'b0, 1'b0};
        vecs[12] = '{11'd3,   11'd5,   1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{11'd3,   11'd5,   1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{11'd3,   11'd480, 1'b0, 1'b0, 1'b0, BG,      1'b0, 1'b0, 1'b0};
        vecs[15] = '{11'd640, 11'd5,   1'b0, 1'b1, 1'b0, BG,      1'b1, 1'b0, 1'b0};
        vecs[16] = '{11'd4,   11'd5,   1'b0, 1'b0, 1'b0, FG,      1'b0, 1'b0, 1'b0};
        vecs[17] = '{11'd3,   11'd21,  1'b0, 1'b0, 1'b0, FG,      1'b0, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_blank", {11'd0, blank_out}, 12'd1);
        chk("reset_hsync", {11'd0, hsync_out}, 12'd0);
        chk("reset_vsync", {11'd0, vsync_out}, 12'd0);
        hsync_in = 1'b0;
        rst_n = 1'b1;

        // Streamed table: output sampled at negedge j belongs to the vector driven at negedge j-3
        for (int j = 0; j < NV + 3; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                chk($sformatf("vec%0d_rgb", j - 3), rgb, vecs[j-3].exp_rgb);
                chk($sformatf("vec%0d_hs", j - 3), {11'd0, hsync_out}, {11'd0, vecs[j-3].exp_hs});
                chk($sformatf("vec%0d_vs", j - 3), {11'd0, vsync_out}, {11'd0, vecs[j-3].exp_vs});
                chk($sformatf("vec%0d_blank", j - 3), {11'd0, blank_out},
                    {11'd0, vecs[j-3].exp_blank});
            end
            if (j < NV) begin
                hcount = vecs[j].hc; vcount = vecs[j].vc; blank_in = vecs[j].blank;
                hsync_in = vecs[j].hs; vsync_in = vecs[j].vs;
            end else begin
                hcount = 11'd0; vcount = 11'd0; blank_in = 1'b1;
                hsync_in = 1'b0; vsync_in = 1'b0;
            end
        end

        // Address generation
        @(negedge clk);
        hcount = 11'd17; vcount = 11'd35; blank_in = 1'b0;
        #1 chk("text_addr_162", text_addr, 12'd162);
        @(posedge clk); #1 chk("char_address", char_address, 12'h413);
        @(negedge clk); hcount = 11'd640; vcount = 11'd5;
        #1 chk("text_addr_col80", text_addr, 12'd0);
        hcount = 11'd0; vcount = 11'd480;
        #1 chk("text_addr_row30", text_addr, 12'd0);
        hcount = 11'd639; vcount = 11'd479;
        #1 chk("text_addr_last", text_addr, 12'd2399);

        // Mid-line asynchronous reset and recovery
        @(negedge clk); hcount = 11'd3; vcount = 11'd5; blank_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_rgb", rgb, FG);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_rgb", rgb, 12'h000);
        chk("async_reset_blank", {11'd0, blank_out}, 12'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("recover_2_rgb", rgb, 12'h000);
        chk("recover_2_blank", {11'd0, blank_out}, 12'd1);
        @(negedge clk);
        chk("recover_3_rgb", rgb, FG);
        chk("recover_3_blank", {11'd0, blank_out}, 12'd0);

        // Cursor and blink
        cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
        pix(11'd0, 11'd14, FG, "cursor_on");
        pix(11'd0, 11'd13, BG, "cursor_row13");
        pix(11'd8, 11'd14, BG, "cursor_other_col");
        vs_pulses(32);
        pix(11'd0, 11'd14, BG, "cursor_blink_off");
        vs_pulses(32);
        pix(11'd0, 11'd14, FG, "cursor_blink_on");
        cursor_en = 1'b0;
        pix(11'd0, 11'd14, BG, "cursor_disabled");
        cursor_en = 1'b1;

        // Reset must clear a partially advanced frame counter
        vs_pulses(5);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        pix(11'd0, 11'd14, FG, "cursor_after_reset");
        vs_pulses(31);
        pix(11'd0, 11'd14, FG, "cursor_31_edges");
        vs_pulses(1);
        pix(11'd0, 11'd14, BG, "cursor_32_edges");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
